// File: rtl/mvprod_chunk_sequencer_if.sv
// Handshake bundle between mvprod_chunk_sequencer, its byte streams and one MVProd engine.
// slave = sequencer side, master = surrounding environment side.
`timescale 1ns/1ps

interface mvprod_chunk_sequencer_if #(
    parameter int WORKING_REGS = 4
);
    logic                        load_valid;
    logic signed [7:0]           load_data;
    logic                        load_ready;
    logic                        mv_in_data_ready;
    logic [WORKING_REGS*8-1:0]   mv_in_data;
    logic                        mv_req_chunk_in;
    logic                        mv_req_chunk_ptr_rst;
    logic                        mv_req_chunk_out;
    logic signed [7:0]           mv_write_out_data;
    logic                        mv_out_vector_valid;
    logic                        res_valid;
    logic signed [7:0]           res_data;
    logic                        res_ready;
    logic                        busy;
    logic [1:0]                  err;

    modport slave (
        input  load_valid, load_data,
        input  mv_req_chunk_in, mv_req_chunk_ptr_rst, mv_req_chunk_out,
        input  mv_write_out_data, mv_out_vector_valid,
        input  res_ready,
        output load_ready, mv_in_data_ready, mv_in_data,
        output res_valid, res_data, busy, err
    );

    modport master (
        output load_valid, load_data,
        output mv_req_chunk_in, mv_req_chunk_ptr_rst, mv_req_chunk_out,
        output mv_write_out_data, mv_out_vector_valid,
        output res_ready,
        input  load_ready, mv_in_data_ready, mv_in_data,
        input  res_valid, res_data, busy, err
    );
endinterface

// File: rtl/mvprod_chunk_sequencer.sv
// Buffers an input vector, feeds it to one MVProd engine chunk by chunk, collects and drains the result.
// Optional RUN inactivity watchdog: define MVSEQ_WATCHDOG_EN.
`timescale 1ns/1ps

// state | meaning
// IDLE  | waiting for the first input byte
// LOAD  | collecting the remaining input bytes
// RUN   | MVProd computing; chunks served, output bytes captured
// DRAIN | result vector streamed out over res_valid/res_ready
module mvprod_chunk_sequencer #(
    parameter int IN_LEN          = 16,
    parameter int OUT_LEN         = 8,
    parameter int WORKING_REGS    = 4,
    parameter int WATCHDOG_CYCLES = 1024
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    mvprod_chunk_sequencer_if.slave  bus
);
    localparam int NCHUNK  = IN_LEN / WORKING_REGS;
    localparam int CHUNK_W = WORKING_REGS * 8;
    localparam int CP_W    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int LN_W    = (WORKING_REGS > 1) ? $clog2(WORKING_REGS) : 1;
    localparam int WR_W    = $clog2(OUT_LEN + 1);
    localparam int DR_W    = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;

    localparam logic [CP_W-1:0] LAST_CHUNK = CP_W'(NCHUNK - 1);
    localparam logic [LN_W-1:0] LAST_LANE  = LN_W'(WORKING_REGS - 1);
    localparam logic [WR_W-1:0] OUT_FULL   = WR_W'(OUT_LEN);
    localparam logic [DR_W-1:0] LAST_DR    = DR_W'(OUT_LEN - 1);

    if ((IN_LEN % WORKING_REGS) != 0 || OUT_LEN < 1 || WATCHDOG_CYCLES < 1) begin : g_cfg_check
        $error("mvprod_chunk_sequencer: invalid parameter set");
    end

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN} state_t;

    state_t              state;
    logic [CHUNK_W-1:0]  in_buf [NCHUNK];
    logic [7:0]          out_buf [OUT_LEN];

    // ld_idx is kept split into chunk/lane so the buffer write needs no multiply
    logic [CP_W-1:0]     ld_chunk;
    logic [LN_W-1:0]     ld_lane;
    logic [CP_W-1:0]     rd_ptr;
    logic [WR_W-1:0]     wr_idx;
    logic [DR_W-1:0]     dr_idx;

    logic                load_ready_q;
    logic                start_q;
    logic                res_valid_q;
    logic                busy_q;
    logic                err_cnt_q;
    logic                err_wd;

    logic                load_acc;
    logic                ld_last;
    logic                cap_req;
    logic                cap_ok;
    logic [WR_W-1:0]     wr_idx_post;
    logic [CP_W-1:0]     rd_ptr_inc;

    assign load_acc    = bus.load_valid & load_ready_q;
    assign ld_last     = (ld_chunk == LAST_CHUNK) && (ld_lane == LAST_LANE);
    assign cap_req     = (state == S_RUN) && bus.mv_req_chunk_out;
    assign cap_ok      = cap_req && (wr_idx != OUT_FULL);
    assign wr_idx_post = cap_ok ? wr_idx + 1'b1 : wr_idx;
    assign rd_ptr_inc  = (rd_ptr == LAST_CHUNK) ? '0 : rd_ptr + 1'b1;

`ifdef MVSEQ_WATCHDOG_EN
    localparam int WD_W = (WATCHDOG_CYCLES > 1) ? $clog2(WATCHDOG_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt;
    logic            err_wd_q;
    logic            wd_activity;

    assign wd_activity = bus.mv_req_chunk_in | bus.mv_req_chunk_ptr_rst | bus.mv_req_chunk_out;
    assign err_wd      = err_wd_q;
`else
    assign err_wd = 1'b0;
`endif

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state        <= S_IDLE;
            ld_chunk     <= '0;
            ld_lane      <= '0;
            rd_ptr       <= '0;
            wr_idx       <= '0;
            dr_idx       <= '0;
            load_ready_q <= 1'b1;
            start_q      <= 1'b0;
            res_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            err_cnt_q    <= 1'b0;
`ifdef MVSEQ_WATCHDOG_EN
            wd_cnt       <= '0;
            err_wd_q     <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE, S_LOAD: begin
                    if (load_acc) begin
                        busy_q <= 1'b1;
                        if (ld_last) begin
                            ld_chunk     <= '0;
                            ld_lane      <= '0;
                            rd_ptr       <= '0;
                            wr_idx       <= '0;
                            load_ready_q <= 1'b0;
                            start_q      <= 1'b1;
                            state        <= S_RUN;
`ifdef MVSEQ_WATCHDOG_EN
                            wd_cnt       <= '0;
`endif
                        end else begin
                            state <= S_LOAD;
                            if (ld_lane == LAST_LANE) begin
                                ld_lane  <= '0;
                                ld_chunk <= ld_chunk + 1'b1;
                            end else begin
                                ld_lane <= ld_lane + 1'b1;
                            end
                        end
                    end
                end

                S_RUN: begin
                    start_q <= 1'b0;
                    // MVProd captures chunk 0 on the start edge, so the pointer moves there too
                    if (bus.mv_req_chunk_ptr_rst)
                        rd_ptr <= '0;
                    else if (start_q || bus.mv_req_chunk_in)
                        rd_ptr <= rd_ptr_inc;

                    if (cap_req) begin
                        wr_idx <= wr_idx_post;
                        if (!cap_ok)
                            err_cnt_q <= 1'b1;
                    end

                    if (bus.mv_out_vector_valid) begin
                        if (wr_idx_post != OUT_FULL)
                            err_cnt_q <= 1'b1;
                        state       <= S_DRAIN;
                        dr_idx      <= '0;
                        res_valid_q <= 1'b1;
                    end
`ifdef MVSEQ_WATCHDOG_EN
                    else if (wd_activity) begin
                        wd_cnt <= '0;
                    end else if (wd_cnt == WD_LAST) begin
                        err_wd_q    <= 1'b1;
                        state       <= S_DRAIN;
                        dr_idx      <= '0;
                        res_valid_q <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`endif
                end

                S_DRAIN: begin
                    if (res_valid_q && bus.res_ready) begin
                        if (dr_idx == LAST_DR) begin
                            dr_idx       <= '0;
                            res_valid_q  <= 1'b0;
                            busy_q       <= 1'b0;
                            load_ready_q <= 1'b1;
                            state        <= S_IDLE;
                        end else begin
                            dr_idx <= dr_idx + 1'b1;
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    // Buffers are plain storage: reset leaves their contents alone
    always_ff @(posedge clk_in) begin
        if (load_acc) begin
            for (int c = 0; c < NCHUNK; c++) begin
                for (int j = 0; j < WORKING_REGS; j++) begin
                    if (ld_chunk == CP_W'(c) && ld_lane == LN_W'(j))
                        in_buf[c][j*8 +: 8] <= bus.load_data;
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (cap_ok)
            out_buf[wr_idx[DR_W-1:0]] <= bus.mv_write_out_data;
    end

    assign bus.load_ready       = load_ready_q;
    assign bus.mv_in_data_ready = start_q;
    assign bus.mv_in_data       = in_buf[rd_ptr];
    assign bus.res_valid        = res_valid_q;
    assign bus.res_data         = out_buf[dr_idx];
    assign bus.busy             = busy_q;
    assign bus.err              = {err_wd, err_cnt_q};
endmodule

// File: tb/tb_mvprod_chunk_sequencer.sv
// Directed bench for mvprod_chunk_sequencer with IN_LEN=8, OUT_LEN=2, WORKING_REGS=4.
// Builds with or without MVSEQ_WATCHDOG_EN (WATCHDOG_CYCLES=20).
`timescale 1ns/1ps

module tb_mvprod_chunk_sequencer;
    localparam int IN_LEN  = 8;
    localparam int OUT_LEN = 2;
    localparam int WREGS   = 4;
    localparam int WDOG    = 20;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    int   n_cmp  = 0;
    int   n_err  = 0;

    always #5 clk_in = ~clk_in;

    mvprod_chunk_sequencer_if #(.WORKING_REGS(WREGS)) bus ();

    mvprod_chunk_sequencer #(
        .IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN), .WORKING_REGS(WREGS), .WATCHDOG_CYCLES(WDOG)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .bus   (bus)
    );

    typedef struct {
        logic        lv;
        logic [7:0]  ld;
        logic        prst;
        logic        cin;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [9];

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_chunk(input logic [7:0] b);
        return {8'(b + 8'd3), 8'(b + 8'd2), 8'(b + 8'd1), b};
    endfunction

    task automatic load_vec(input logic [7:0] base);
        for (int i = 0; i < IN_LEN; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = 8'(base + 8'(i));
            step();
        end
        bus.load_valid = 1'b0;
    endtask

    task automatic strobe(input logic [7:0] d, input logic vv);
        bus.mv_req_chunk_out    = 1'b1;
        bus.mv_write_out_data   = d;
        bus.mv_out_vector_valid = vv;
        step();
        bus.mv_req_chunk_out    = 1'b0;
        bus.mv_out_vector_valid = 1'b0;
    endtask

    task automatic vec_valid();
        bus.mv_out_vector_valid = 1'b1;
        step();
        bus.mv_out_vector_valid = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst_in = 1'b1;
        #2 rst_in = 1'b0;
        step();
    endtask

    initial begin
        logic [31:0] c0, c1;
        bus.load_valid           = 1'b0;
        bus.load_data            = '0;
        bus.mv_req_chunk_in      = 1'b0;
        bus.mv_req_chunk_ptr_rst = 1'b0;
        bus.mv_req_chunk_out     = 1'b0;
        bus.mv_write_out_data    = '0;
        bus.mv_out_vector_valid  = 1'b0;
        bus.res_ready            = 1'b0;

        c0 = exp_chunk(8'd1);
        c1 = exp_chunk(8'd5);
        vecs[0] = '{lv:1'b1, ld:8'hFF, prst:1'b0, cin:1'b0, exp_data:c1};
        vecs[1] = '{lv:1'b0, ld:8'h00, prst:1'b0, cin:1'b1, exp_data:c0};
        vecs[2] = '{lv:1'b0, ld:8'h00, prst:1'b0, cin:1'b1, exp_data:c1};
        vecs[3] = '{lv:1'b0, ld:8'h00, prst:1'b1, cin:1'b0, exp_data:c0};
        vecs[4] = '{lv:1'b0, ld:8'h00, prst:1'b0, cin:1'b0, exp_data:c0};
        vecs[5] = '{lv:1'b0, ld:8'h00, prst:1'b0, cin:1'b1, exp_data:c1};
        vecs[6] = '{lv:1'b0, ld:8'h00, prst:1'b1, cin:1'b1, exp_data:c0};
        vecs[7] = '{lv:1'b1, ld:8'h77, prst:1'b0, cin:1'b1, exp_data:c1};
        vecs[8] = '{lv:1'b1, ld:8'h55, prst:1'b1, cin:1'b1, exp_data:c0};

        // reset values while rst_in is held
        #12;
        chk("rst_load_ready", {31'd0, bus.load_ready}, 32'd1);
        chk("rst_start", {31'd0, bus.mv_in_data_ready}, 32'd0);
        chk("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_err", {30'd0, bus.err}, 32'd0);
        rst_in = 1'b0;
        step();

        // MVProd strobes in IDLE are ignored
        bus.mv_req_chunk_out = 1'b1;
        bus.mv_out_vector_valid = 1'b1;
        bus.mv_req_chunk_in = 1'b1;
        step();
        bus.mv_req_chunk_out = 1'b0;
        bus.mv_out_vector_valid = 1'b0;
        bus.mv_req_chunk_in = 1'b0;
        chk("idle_strobe_err", {30'd0, bus.err}, 32'd0);
        chk("idle_strobe_busy", {31'd0, bus.busy}, 32'd0);
        chk("idle_strobe_res_valid", {31'd0, bus.res_valid}, 32'd0);

        // load 1..8, start pulse with chunk 0
        load_vec(8'd1);
        chk("run_busy", {31'd0, bus.busy}, 32'd1);
        chk("run_load_ready", {31'd0, bus.load_ready}, 32'd0);
        chk("run_start", {31'd0, bus.mv_in_data_ready}, 32'd1);
        chk("run_chunk0", bus.mv_in_data, c0);
        step();
        chk("run_start_drop", {31'd0, bus.mv_in_data_ready}, 32'd0);
        chk("run_chunk1", bus.mv_in_data, c1);

        // chunk pointer vectors
        for (int i = 0; i < 9; i++) begin
            bus.load_valid           = vecs[i].lv;
            bus.load_data            = vecs[i].ld;
            bus.mv_req_chunk_ptr_rst = vecs[i].prst;
            bus.mv_req_chunk_in      = vecs[i].cin;
            step();
            chk($sformatf("vec%0d_data", i), bus.mv_in_data, vecs[i].exp_data);
            chk($sformatf("vec%0d_load_ready", i), {31'd0, bus.load_ready}, 32'd0);
        end
        bus.load_valid           = 1'b0;
        bus.mv_req_chunk_ptr_rst = 1'b0;
        bus.mv_req_chunk_in      = 1'b0;

        // 30, -12 then vector valid, drained back to back
        bus.res_ready = 1'b1;
        strobe(8'd30, 1'b0);
        strobe(8'hF4, 1'b0);
        vec_valid();
        chk("drain_a_valid0", {31'd0, bus.res_valid}, 32'd1);
        chk("drain_a_data0", {24'd0, bus.res_data}, 32'd30);
        step();
        chk("drain_a_valid1", {31'd0, bus.res_valid}, 32'd1);
        chk("drain_a_data1", {24'd0, bus.res_data}, 32'hF4);
        step();
        chk("drain_a_done_valid", {31'd0, bus.res_valid}, 32'd0);
        chk("drain_a_done_busy", {31'd0, bus.busy}, 32'd0);
        chk("drain_a_err", {30'd0, bus.err}, 32'd0);
        chk("drain_a_load_ready", {31'd0, bus.load_ready}, 32'd1);
        bus.res_ready = 1'b0;

        // three strobes into a two-entry result
        load_vec(8'd11);
        chk("ovf_chunk0", bus.mv_in_data, exp_chunk(8'd11));
        step();
        strobe(8'd5, 1'b0);
        strobe(8'd6, 1'b0);
        chk("ovf_err_before", {30'd0, bus.err}, 32'd0);
        strobe(8'd7, 1'b0);
        chk("ovf_err_after", {30'd0, bus.err}, 32'd1);
        vec_valid();
        chk("ovf_data0", {24'd0, bus.res_data}, 32'd5);
        step();
        chk("ovf_hold_valid", {31'd0, bus.res_valid}, 32'd1);
        chk("ovf_hold_data", {24'd0, bus.res_data}, 32'd5);
        bus.res_ready = 1'b1;
        step();
        chk("ovf_data1", {24'd0, bus.res_data}, 32'd6);
        step();
        chk("ovf_done_valid", {31'd0, bus.res_valid}, 32'd0);
        chk("ovf_err_sticky", {30'd0, bus.err}, 32'd1);
        bus.res_ready = 1'b0;

        // capture and vector valid in the same cycle
        do_reset();
        chk("clr_err", {30'd0, bus.err}, 32'd0);
        load_vec(8'd1);
        step();
        strobe(8'd9, 1'b0);
        strobe(8'd10, 1'b1);
        chk("same_cyc_err", {30'd0, bus.err}, 32'd0);
        chk("same_cyc_data0", {24'd0, bus.res_data}, 32'd9);
        bus.res_ready = 1'b1;
        step();
        chk("same_cyc_data1", {24'd0, bus.res_data}, 32'd10);
        step();
        chk("same_cyc_busy", {31'd0, bus.busy}, 32'd0);

        // vector valid after a single strobe
        load_vec(8'd1);
        step();
        strobe(8'd4, 1'b0);
        vec_valid();
        chk("short_err", {30'd0, bus.err}, 32'd1);
        chk("short_data0", {24'd0, bus.res_data}, 32'd4);
        step();
        chk("short_data1_stale", {24'd0, bus.res_data}, 32'd10);
        step();
        chk("short_busy", {31'd0, bus.busy}, 32'd0);
        bus.res_ready = 1'b0;

        // asynchronous reset during the first RUN cycle
        load_vec(8'd1);
        chk("arst_pre_start", {31'd0, bus.mv_in_data_ready}, 32'd1);
        #2 rst_in = 1'b1;
        #0.5;
        chk("arst_busy", {31'd0, bus.busy}, 32'd0);
        chk("arst_load_ready", {31'd0, bus.load_ready}, 32'd1);
        chk("arst_start", {31'd0, bus.mv_in_data_ready}, 32'd0);
        chk("arst_res_valid", {31'd0, bus.res_valid}, 32'd0);
        chk("arst_err", {30'd0, bus.err}, 32'd0);
        #0.5 rst_in = 1'b0;
        step();
        load_vec(8'd21);
        chk("reload_start", {31'd0, bus.mv_in_data_ready}, 32'd1);
        chk("reload_chunk0", bus.mv_in_data, exp_chunk(8'd21));
        step();
        chk("reload_chunk1", bus.mv_in_data, exp_chunk(8'd25));

        // MVProd silent after start
        for (int i = 0; i < WDOG - 2; i++) step();
        chk("silent_pre_res_valid", {31'd0, bus.res_valid}, 32'd0);
        chk("silent_pre_busy", {31'd0, bus.busy}, 32'd1);
        step();
`ifdef MVSEQ_WATCHDOG_EN
        chk("wd_res_valid", {31'd0, bus.res_valid}, 32'd1);
        chk("wd_err", {30'd0, bus.err}, 32'd2);
        chk("wd_data0", {24'd0, bus.res_data}, 32'd4);
        bus.res_ready = 1'b1;
        step();
        chk("wd_data1", {24'd0, bus.res_data}, 32'd10);
        step();
        chk("wd_done_busy", {31'd0, bus.busy}, 32'd0);
        chk("wd_err_sticky", {30'd0, bus.err}, 32'd2);
        bus.res_ready = 1'b0;
`else
        chk("nowd_res_valid", {31'd0, bus.res_valid}, 32'd0);
        chk("nowd_err", {30'd0, bus.err}, 32'd0);
        for (int i = 0; i < 2 * WDOG; i++) step();
        chk("nowd_still_busy", {31'd0, bus.busy}, 32'd1);
        chk("nowd_still_res_valid", {31'd0, bus.res_valid}, 32'd0);
        vec_valid();
        chk("nowd_late_err", {30'd0, bus.err}, 32'd1);
        chk("nowd_late_res_valid", {31'd0, bus.res_valid}, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
